// File: rtl/gsel_loader_pkg.sv
// Shared definitions for the game-select loader.
//   state_e            : loader FSM states
//   FrameLen           : serial frame length in bits ({IDX, CHK})
//   BitCntMax          : saturated bit count that marks an overrun frame
//   BitCntW            : width of the bit counter
//   DefaultHoldCycles  : default pseudo-reset hold time in CLK_12M cycles
package gsel_loader_pkg;

  localparam int unsigned FrameLen          = 16;
  localparam int unsigned BitCntMax         = FrameLen + 1;
  localparam int unsigned BitCntW           = 5;
  localparam int unsigned DefaultHoldCycles = 4096;

  typedef enum logic [2:0] {
    StIdle,
    StShift,
    StCheck,
    StHold,
    StApply
  } state_e;

endpackage

// File: rtl/gsel_sync.sv
// Multi-stage synchronizer with rising-edge detector.
//   clk_i  : destination clock
//   rst_i  : synchronous active-high reset, clears all stages
//   d_i    : asynchronous input
//   q_o    : synchronized level
//   rise_o : one-cycle pulse when the synchronized level goes 0 -> 1
module gsel_sync #(
  parameter int unsigned SyncStages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o
);

  logic [SyncStages-1:0] sync_d, sync_q;
  logic                  prev_d, prev_q;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = d_i;
    for (int i = 1; i < SyncStages; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  assign q_o    = sync_q[SyncStages-1];
  assign prev_d = q_o;
  assign rise_o = q_o & ~prev_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/gsel_loader.sv
// Game-select loader: receives a 16-bit {IDX, CHK} frame over an asynchronous
// SCLK/SDAT/SLAT serial link, validates it, holds GSEL at 0 (pseudo-reset) for
// HOLD_CYCLES, then applies the new game index.
//   CLK_12M : system clock
//   RESET   : synchronous active-high reset
//   SCLK    : serial clock, data sampled on rising edge
//   SDAT    : serial data, MSB first
//   SLAT    : latch strobe, rising edge ends a frame
//   GSEL    : registered game select, 0 = pseudo-reset
//   BUSY    : high from frame acceptance until GSEL is applied
//   ACK     : one-cycle pulse when GSEL is applied
//   ERR     : sticky frame error, cleared by a valid frame or RESET
module gsel_loader
  import gsel_loader_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = DefaultHoldCycles,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK_12M,
  input  logic       RESET,
  input  logic       SCLK,
  input  logic       SDAT,
  input  logic       SLAT,
  output logic [7:0] GSEL,
  output logic       BUSY,
  output logic       ACK,
  output logic       ERR
);

  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLD_CYCLES - 1);

  logic sclk_s, sclk_rise;
  logic sdat_s, sdat_rise;
  logic slat_s, slat_rise;

  gsel_sync #(.SyncStages(SYNC_STAGES)) u_sync_sclk (
    .clk_i  (CLK_12M),
    .rst_i  (RESET),
    .d_i    (SCLK),
    .q_o    (sclk_s),
    .rise_o (sclk_rise)
  );

  gsel_sync #(.SyncStages(SYNC_STAGES)) u_sync_sdat (
    .clk_i  (CLK_12M),
    .rst_i  (RESET),
    .d_i    (SDAT),
    .q_o    (sdat_s),
    .rise_o (sdat_rise)
  );

  gsel_sync #(.SyncStages(SYNC_STAGES)) u_sync_slat (
    .clk_i  (CLK_12M),
    .rst_i  (RESET),
    .d_i    (SLAT),
    .q_o    (slat_s),
    .rise_o (slat_rise)
  );

  logic unused_sync;
  assign unused_sync = ^{sclk_s, sdat_rise, slat_s};

  state_e               state_d, state_q;
  logic [FrameLen-1:0]  sr_d, sr_q;
  logic [BitCntW-1:0]   bcnt_d, bcnt_q;
  logic [CntW-1:0]      hcnt_d, hcnt_q;
  logic [7:0]           pend_d, pend_q;
  logic [7:0]           gsel_d, gsel_q;
  logic                 busy_d, busy_q;
  logic                 ack_d, ack_q;
  logic                 err_d, err_q;
  logic                 frame_ok;

  assign frame_ok = (bcnt_q == BitCntW'(FrameLen)) &&
                    (sr_q[7:0] == ~sr_q[15:8]) &&
                    (sr_q[15:8] != 8'h00);

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    hcnt_d  = hcnt_q;
    pend_d  = pend_q;
    gsel_d  = gsel_q;
    busy_d  = busy_q;
    ack_d   = 1'b0;
    err_d   = err_q;

    unique case (state_q)
      StIdle: begin
        if (sclk_rise) begin
          sr_d    = {sr_q[FrameLen-2:0], sdat_s};
          bcnt_d  = BitCntW'(1);
          // A latch coincident with the first bit still goes through CHECK,
          // which rejects it on the bit count.
          state_d = slat_rise ? StCheck : StShift;
        end else if (slat_rise) begin
          err_d = 1'b1;
        end
      end
      StShift: begin
        if (sclk_rise) begin
          sr_d   = {sr_q[FrameLen-2:0], sdat_s};
          bcnt_d = (bcnt_q >= BitCntW'(BitCntMax)) ? BitCntW'(BitCntMax)
                                                    : bcnt_q + BitCntW'(1);
        end
        if (slat_rise) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        bcnt_d = '0;
        if (frame_ok) begin
          err_d   = 1'b0;
          pend_d  = sr_q[15:8];
          gsel_d  = 8'h00;
          hcnt_d  = HoldLoad;
          busy_d  = 1'b1;
          state_d = StHold;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StHold: begin
        // Serial edges are deliberately ignored while the games sit in reset.
        if (hcnt_q == '0) begin
          state_d = StApply;
        end else begin
          hcnt_d = hcnt_q - CntW'(1);
        end
      end
      StApply: begin
        gsel_d  = pend_q;
        ack_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge CLK_12M) begin
    if (RESET) begin
      state_q <= StIdle;
      sr_q    <= '0;
      bcnt_q  <= '0;
      hcnt_q  <= '0;
      pend_q  <= '0;
      gsel_q  <= '0;
      busy_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      hcnt_q  <= hcnt_d;
      pend_q  <= pend_d;
      gsel_q  <= gsel_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign GSEL = gsel_q;
  assign BUSY = busy_q;
  assign ACK  = ack_q;
  assign ERR  = err_q;

endmodule

// File: tb/tb_gsel_loader.sv
// Directed bench for gsel_loader with HOLD_CYCLES=8, SYNC_STAGES=2.
module tb_gsel_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       sdat = 1'b0;
  logic       slat = 1'b0;
  logic [7:0] gsel;
  logic       busy;
  logic       ack;
  logic       err;

  int checks = 0;
  int errors = 0;
  int ack_cnt = 0;
  int ack_base;

  gsel_loader #(.HOLD_CYCLES(8), .SYNC_STAGES(2)) dut (
    .CLK_12M (clk),
    .RESET   (rst),
    .SCLK    (sclk),
    .SDAT    (sdat),
    .SLAT    (slat),
    .GSEL    (gsel),
    .BUSY    (busy),
    .ACK     (ack),
    .ERR     (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ack === 1'b1) ack_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Shifts the low n bits of v out MSB first.
  task automatic send_bits(input logic [16:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sdat = v[i];
      tick(1);
      sclk = 1'b1;
      tick(1);
      sclk = 1'b0;
      tick(1);
    end
  endtask

  task automatic latch();
    slat = 1'b1;
    tick(1);
    slat = 1'b0;
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (busy === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
    if (!ok) check("busy_timeout", 32'(busy), 32'd1);
  endtask

  // Follows one accepted frame cycle by cycle from the first BUSY cycle.
  task automatic run_apply(input logic [7:0] exp, input bit disturb);
    bit ok;
    wait_busy(ok);
    if (!ok) return;
    ack_base = ack_cnt;
    check("err_clr", 32'(err), 32'd0);
    for (int k = 0; k <= 10; k++) begin
      if (k <= 8) begin
        check($sformatf("hold_gsel%0d", k), 32'(gsel), 32'h0);
        check($sformatf("hold_busy%0d", k), 32'(busy), 32'd1);
        check($sformatf("hold_ack%0d", k), 32'(ack), 32'd0);
      end else if (k == 9) begin
        check("apply_gsel", 32'(gsel), 32'(exp));
        check("apply_ack", 32'(ack), 32'd1);
        check("apply_busy", 32'(busy), 32'd0);
      end else begin
        check("post_gsel", 32'(gsel), 32'(exp));
        check("post_ack", 32'(ack), 32'd0);
      end
      if (disturb) begin
        sdat = 1'b1;
        sclk = (k == 1) || (k == 3);
        slat = (k == 2) || (k == 4);
      end
      if (k < 10) tick(1);
    end
    sclk = 1'b0;
    slat = 1'b0;
    sdat = 1'b0;
    tick(4);
    check("ack_once", 32'(ack_cnt - ack_base), 32'd1);
    check("err_after", 32'(err), 32'd0);
  endtask

  initial begin
    bit ok;

    // Reset
    rst = 1'b1;
    tick(3);
    check("rst_gsel", 32'(gsel), 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick(2);

    // Valid frame 0x05FA
    send_bits(17'h05FA, 16);
    latch();
    run_apply(8'h05, 1'b0);

    // Bad checksum
    ack_base = ack_cnt;
    send_bits(17'h05FB, 16);
    latch();
    tick(15);
    check("badchk_err", 32'(err), 32'd1);
    check("badchk_gsel", 32'(gsel), 32'h05);
    check("badchk_busy", 32'(busy), 32'd0);
    check("badchk_ack", 32'(ack_cnt - ack_base), 32'd0);

    // Valid 0x2AD5 clears ERR
    send_bits(17'h2AD5, 16);
    latch();
    run_apply(8'h2A, 1'b0);

    // 15 bits; leftover register bit makes it 0xAA55, caught only by the count
    send_bits(17'h2A55, 15);
    latch();
    tick(15);
    check("short_err", 32'(err), 32'd1);
    check("short_gsel", 32'(gsel), 32'h2A);

    send_bits(17'h05FA, 16);
    latch();
    run_apply(8'h05, 1'b0);

    // 17 bits; last 16 alone would be a valid frame
    send_bits(17'h12AD5, 17);
    latch();
    tick(15);
    check("long_err", 32'(err), 32'd1);
    check("long_gsel", 32'(gsel), 32'h05);

    // Valid frame with stray SCLK/SLAT edges during HOLD
    send_bits(17'h2AD5, 16);
    latch();
    run_apply(8'h2A, 1'b1);

    // SLAT with no bits received
    latch();
    tick(6);
    check("idle_slat_err", 32'(err), 32'd1);
    check("idle_slat_gsel", 32'(gsel), 32'h2A);

    // RESET during HOLD
    send_bits(17'h05FA, 16);
    latch();
    wait_busy(ok);
    tick(3);
    ack_base = ack_cnt;
    rst = 1'b1;
    tick(1);
    check("midrst_gsel", 32'(gsel), 32'h0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick(15);
    check("midrst_gsel_hold", 32'(gsel), 32'h0);
    check("midrst_no_ack", 32'(ack_cnt - ack_base), 32'd0);

    // IDX 0 rejected
    send_bits(17'h00FF, 16);
    latch();
    tick(15);
    check("idx0_err", 32'(err), 32'd1);
    check("idx0_gsel", 32'(gsel), 32'h0);
    check("idx0_busy", 32'(busy), 32'd0);

    // Last SCLK edge coincident with SLAT
    send_bits(17'h33CC >> 1, 15);
    sdat = 1'b0;
    tick(1);
    sclk = 1'b1;
    slat = 1'b1;
    tick(1);
    sclk = 1'b0;
    slat = 1'b0;
    run_apply(8'h33, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
